// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and constants for the
// boot-time instruction memory loader.
package imem_loader_pkg;

   localparam int HDR_W          = 16;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
      CHK,
      DONE,
      ERR
   } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: little-endian byte-to-word shift register.
// word_o already includes the byte being accepted this cycle.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    byte_i,
   input  logic                          accept_i,
   input  logic                          clear_i,
   output logic [8*BYTES_PER_WORD-1:0]   word_o,
   output logic                          word_full_o
);

   logic [8*BYTES_PER_WORD-1:0] sr_q;
   logic [8*BYTES_PER_WORD-1:0] sr_d;
   logic [1:0]                  cnt_q;

   // Newest byte enters at the top so byte0 ends up in [7:0].
   assign sr_d        = {byte_i, sr_q[8*BYTES_PER_WORD-1:8]};
   assign word_o      = sr_d;
   assign word_full_o = accept_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (accept_i) begin
         sr_q  <= sr_d;
         cnt_q <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int INS_ADDRESS = 9,
   parameter int INS_W       = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_start,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   output logic                   we,
   output logic [INS_ADDRESS-1:0] wa,
   output logic [INS_W-1:0]       wd,
   output logic                   cpu_hold,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   localparam int IDX_W = INS_ADDRESS - 2;
   localparam int DEPTH = 1 << IDX_W;

   state_e                 state_q;
   logic [HDR_W-1:0]       count_q;
   logic [IDX_W-1:0]       word_idx_q;
   logic                   we_q;
   logic [INS_ADDRESS-1:0] wa_q;
   logic [INS_W-1:0]       wd_q;
   logic                   cpu_hold_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   error_q;
`ifdef IMEM_LOADER_CHKSUM_EN
   logic [7:0]             xor_q;
`endif

   logic             accept;
   logic             start;
   logic [HDR_W-1:0] hdr_cnt;
   logic             hdr_bad;
   logic             last_word;
   logic             pk_accept;
   logic [INS_W-1:0] pk_word;
   logic             pk_full;

   assign rx_ready = (state_q == HDR0) || (state_q == HDR1) ||
                     (state_q == DATA) || (state_q == CHK);
   assign accept   = rx_valid && rx_ready;
   assign start    = load_start &&
                     ((state_q == IDLE) || (state_q == DONE) ||
                      (state_q == ERR));

   assign hdr_cnt   = {rx_data, count_q[7:0]};
   assign hdr_bad   = (hdr_cnt == '0) || (32'(hdr_cnt) > DEPTH);
   assign last_word = (HDR_W'(word_idx_q) == count_q - HDR_W'(1));
   assign pk_accept = accept && (state_q == DATA);

   imem_loader_byte_packer u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_i      (rx_data),
      .accept_i    (pk_accept),
      .clear_i     (start),
      .word_o      (pk_word),
      .word_full_o (pk_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= '0;
         word_idx_q <= '0;
         we_q       <= 1'b0;
         wa_q       <= '0;
         wd_q       <= '0;
         cpu_hold_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         we_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state_q    <= HDR0;
                  count_q    <= '0;
                  word_idx_q <= '0;
                  cpu_hold_q <= 1'b1;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
                  xor_q      <= '0;
`endif
               end
            end
            HDR0: begin
               if (accept) begin
                  count_q[7:0] <= rx_data;
                  state_q      <= HDR1;
               end
            end
            HDR1: begin
               if (accept) begin
                  count_q <= hdr_cnt;
                  if (hdr_bad) begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHKSUM_EN
               if (accept) xor_q <= xor_q ^ rx_data;
`endif
               if (pk_full) begin
                  we_q    <= 1'b1;
                  wa_q    <= {word_idx_q, 2'b00};
                  wd_q    <= pk_word;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                  state_q    <= CHK;
`else
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  cpu_hold_q <= 1'b0;
`endif
               end else begin
                  word_idx_q <= word_idx_q + 1'b1;
                  state_q    <= DATA;
               end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            CHK: begin
               if (accept) begin
                  busy_q <= 1'b0;
                  if (rx_data == xor_q) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign we       = we_q;
   assign wa       = wa_q;
   assign wd       = wd_q;
   assign cpu_hold = cpu_hold_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Checksum scenario runs only when IMEM_LOADER_CHKSUM_EN is defined.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        we;
   logic [8:0]  wa;
   logic [31:0] wd;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;

   int n_assert = 0;
   int n_fail   = 0;
   int base;

   logic [8:0]  log_a[$];
   logic [31:0] log_d[$];

   always #5 clk = ~clk;

   imem_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .we         (we),
      .wa         (wa),
      .wd         (wd),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always @(posedge clk) begin
      #1;
      if (we === 1'b1) begin
         log_a.push_back(wa);
         log_d.push_back(wd);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         n_assert++;
         n_fail++;
         $error("FAIL rx_ready_timeout: observed 0 expected 1");
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b);
      send_byte(b);
      @(negedge clk);
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic end_load(input logic [7:0] chk);
`ifdef IMEM_LOADER_CHKSUM_EN
      send_byte(chk);
`else
      if (chk !== 8'hxx) @(negedge clk);
`endif
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rx_ready"}, rx_ready, 0);
      check({tag, "_we"}, we, 0);
      check({tag, "_wa"}, wa, 0);
      check({tag, "_wd"}, wd, 0);
      check({tag, "_cpu_hold"}, cpu_hold, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Two-word load
      pulse_start();
      check("s1_busy", busy, 1);
      check("s1_hold", cpu_hold, 1);
      check("s1_ready", rx_ready, 1);
      send_byte(8'h02);
      send_byte(8'h00);
      base = log_a.size();
      send_byte(8'h33);
      send_byte(8'h70);
      send_byte(8'h00);
      send_byte(8'h00);
      check("s1_we0", we, 1);
      check("s1_wa0", wa, 9'h000);
      check("s1_wd0", wd, 32'h0000_7033);
      send_byte(8'h93);
      send_byte(8'h02);
      send_byte(8'hD0);
      send_byte(8'h00);
      check("s1_we1", we, 1);
      check("s1_wa1", wa, 9'h004);
      check("s1_wd1", wd, 32'h00D0_0293);
      end_load(8'h02);
      check("s1_done", done, 1);
      check("s1_hold_rel", cpu_hold, 0);
      check("s1_busy_end", busy, 0);
      check("s1_err", error, 0);
      check("s1_nwrites", log_a.size() - base, 2);

      // Zero header, then recovery load
      pulse_start();
      check("s2_done_clr", done, 0);
      base = log_a.size();
      send_byte(8'h00);
      send_byte(8'h00);
      check("s2_err", error, 1);
      check("s2_hold", cpu_hold, 1);
      check("s2_busy", busy, 0);
      check("s2_ready", rx_ready, 0);
      check("s2_nowrite", log_a.size() - base, 0);
      pulse_start();
      check("s2_err_clr", error, 0);
      check("s2_busy2", busy, 1);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h13);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      end_load(8'h13);
      check("s2_done", done, 1);
      check("s2_wd", log_d[log_d.size()-1], 32'h0000_0013);
      check("s2_wa", log_a[log_a.size()-1], 9'h000);

      // Oversized header 129 words
      pulse_start();
      send_byte(8'h81);
      send_byte(8'h00);
      check("s3_err", error, 1);
      check("s3_ready", rx_ready, 0);

      // 128 words is the limit and is accepted; reset mid-data
      pulse_start();
      send_byte(8'h80);
      send_byte(8'h00);
      check("s3_max_ready", rx_ready, 1);
      check("s3_max_err", error, 0);
      send_byte(8'h33);
      send_byte(8'h70);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h93);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("s5");
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      base = log_a.size();
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h33);
      send_byte(8'h70);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h93);
      send_byte(8'h02);
      send_byte(8'hD0);
      send_byte(8'h00);
      end_load(8'h02);
      check("s5_done", done, 1);
      check("s5_nwrites", log_a.size() - base, 2);
      check("s5_wd1", log_d[base+1], 32'h00D0_0293);

      // Gapped stream with ignored mid-load start
      pulse_start();
      base = log_a.size();
      send_gap(8'h02);
      send_gap(8'h00);
      send_gap(8'h33);
      send_gap(8'h70);
      pulse_start();
      check("s4_busy", busy, 1);
      check("s4_done", done, 0);
      send_gap(8'h00);
      send_gap(8'h00);
      send_gap(8'h93);
      send_gap(8'h02);
      send_gap(8'hD0);
      send_gap(8'h00);
      end_load(8'h02);
      check("s4_done_end", done, 1);
      check("s4_nwrites", log_a.size() - base, 2);
      check("s4_wa0", log_a[base], 9'h000);
      check("s4_wd0", log_d[base], 32'h0000_7033);
      check("s4_wa1", log_a[base+1], 9'h004);
      check("s4_wd1", log_d[base+1], 32'h00D0_0293);

`ifdef IMEM_LOADER_CHKSUM_EN
      // Checksum good and bad
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h44);
      check("s6_done", done, 1);
      check("s6_err", error, 0);
      pulse_start();
      base = log_a.size();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h45);
      check("s6_bad_err", error, 1);
      check("s6_bad_done", done, 0);
      check("s6_bad_hold", cpu_hold, 1);
      check("s6_bad_we", log_a.size() - base, 1);
      check("s6_bad_wd", log_d[base], 32'h4433_2211);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
